// File: rtl/text_buf_pkg.sv
// Shared types and constants for the text buffer writer.
//   state_e      : writer FSM states (idle / clear sweep)
//   ASCII_*      : control and fill byte codes
//   PRINT_LO/HI  : inclusive printable ASCII range
package text_buf_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

endpackage

// File: rtl/text_buffer_writer.sv
// Writer side of the VGA text renderer's character array.
// Takes ASCII bytes over a valid/ready stream, tracks a cursor, handles backspace, form feed
// and a full-array clear sweep. Everything runs on the pixel clock.
// Ports:
//   VGA_CLK_IN  pixel clock
//   rst         synchronous active-high reset
//   in_valid    in_char valid
//   in_char     ASCII byte
//   in_ready    byte accepted at the next edge when in_valid is also high
//   clear_req   level request for a full clear, sampled in idle
//   ram         registered DEPTH x 8-bit character array
//   cursor      next write index (0..VISIBLE)
//   full        cursor == VISIBLE
//   busy        clear sweep in progress
//   overflow    one-cycle pulse when a printable byte is dropped at full
module text_buffer_writer
  import text_buf_pkg::*;
#(
  parameter int unsigned DEPTH   = 65,
  parameter int unsigned VISIBLE = 40,
  parameter logic [7:0]  BLANK   = ASCII_BLANK,
  localparam int unsigned CurW   = $clog2(VISIBLE + 1),
  localparam int unsigned IdxW   = $clog2(DEPTH)
) (
  input  logic            VGA_CLK_IN,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_char,
  output logic            in_ready,
  input  logic            clear_req,
  output logic [7:0]      ram [DEPTH-1:0],
  output logic [CurW-1:0] cursor,
  output logic            full,
  output logic            busy,
  output logic            overflow
);

  localparam logic [CurW-1:0] CurMax  = CurW'(VISIBLE);
  localparam logic [IdxW-1:0] ClrLast = IdxW'(DEPTH - 1);

  state_e          state_q;
  logic [IdxW-1:0] clr_idx_q;
  logic            transfer;
  logic            printable;
  logic [CurW-1:0] cursor_dec;

  assign in_ready   = (state_q == StIdle) && !clear_req && !rst;
  assign transfer   = in_valid && in_ready;
  assign printable  = (in_char >= PRINT_LO) && (in_char <= PRINT_HI);
  assign cursor_dec = cursor - 1'b1;
  assign full       = (cursor == CurMax);

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
      cursor    <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ram[i] <= BLANK;
      end
    end else begin
      overflow <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clear_req) begin
            // in_ready is low here, so any concurrent byte stays with the source.
            state_q   <= StClear;
            clr_idx_q <= '0;
            busy      <= 1'b1;
          end else if (transfer) begin
            if (printable) begin
              if (cursor != CurMax) begin
                ram[IdxW'(cursor)] <= in_char;
                cursor             <= cursor + 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else if (in_char == ASCII_BS) begin
              if (cursor != '0) begin
                ram[IdxW'(cursor_dec)] <= BLANK;
                cursor                 <= cursor_dec;
              end
            end else if (in_char == ASCII_FF) begin
              state_q   <= StClear;
              clr_idx_q <= '0;
              busy      <= 1'b1;
            end
          end
        end
        StClear: begin
          ram[clr_idx_q] <= BLANK;
          if (clr_idx_q == ClrLast) begin
            cursor  <= '0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: stimulus queues expected observations tagged with
// the cycle they are due; a negedge monitor pops and compares them against the DUT outputs.
module tb_text_buffer_writer;

  localparam int Depth   = 65;
  localparam int Visible = 40;
  localparam logic [7:0] Blank = 8'h20;

  typedef enum int {KCur, KRam, KFull, KBusy, KOvf, KRdy} kind_e;
  typedef struct {
    int         due;
    kind_e      kind;
    int         idx;
    logic [7:0] val;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       clear_req;
  logic [7:0] ram [Depth-1:0];
  logic [5:0] cursor;
  logic       full;
  logic       busy;
  logic       overflow;

  text_buffer_writer #(
    .DEPTH  (Depth),
    .VISIBLE(Visible),
    .BLANK  (Blank)
  ) dut (
    .VGA_CLK_IN(clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .clear_req (clear_req),
    .ram       (ram),
    .cursor    (cursor),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  item_t      sb [$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_ram [Depth];
  int         m_cur;

  task automatic push(input kind_e k, input int idx, input logic [7:0] v, input int due);
    item_t it;
    it.due  = due;
    it.kind = k;
    it.idx  = idx;
    it.val  = v;
    sb.push_back(it);
  endtask

  task automatic push_all_ram(input int due);
    for (int i = 0; i < Depth; i++) push(KRam, i, m_ram[i], due);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_blank();
    for (int i = 0; i < Depth; i++) m_ram[i] = Blank;
    m_cur = 0;
  endtask

  // Monitor: compare every item due this cycle; anything older was missed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      item_t      it;
      logic [7:0] act;
      string      nm;
      it = sb.pop_front();
      case (it.kind)
        KCur:    begin act = {2'b00, cursor}; nm = "cursor";   end
        KRam:    begin act = ram[it.idx];     nm = "ram";      end
        KFull:   begin act = {7'd0, full};    nm = "full";     end
        KBusy:   begin act = {7'd0, busy};    nm = "busy";     end
        KOvf:    begin act = {7'd0, overflow}; nm = "overflow"; end
        default: begin act = {7'd0, in_ready}; nm = "in_ready"; end
      endcase
      checks++;
      if (it.due != cyc) begin
        errors++;
        $display("FAIL %s[%0d] missed at cycle %0d (due %0d)", nm, it.idx, cyc, it.due);
      end else if (act !== it.val) begin
        errors++;
        $display("FAIL %s[%0d] cycle %0d: got %h, expected %h", nm, it.idx, cyc, act, it.val);
      end
    end
  end

  // Offer one byte, update the model and queue the expected outcome.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_wait: in_ready=%b after %0d cycles, expected 1", in_ready, guard);
    end
    in_valid = 1'b1;
    in_char  = b;
    push(KRdy, 0, 8'd1, cyc);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_cur < Visible) begin
        m_ram[m_cur] = b;
        push(KRam, m_cur, b, cyc + 1);
        m_cur++;
        push(KOvf, 0, 8'd0, cyc + 1);
      end else begin
        push(KOvf, 0, 8'd1, cyc + 1);
      end
    end else if (b == 8'h08) begin
      if (m_cur > 0) begin
        m_cur--;
        m_ram[m_cur] = Blank;
        push(KRam, m_cur, Blank, cyc + 1);
      end
    end else if (b == 8'h0C) begin
      push(KBusy, 0, 8'd1, cyc + 1);
    end
    push(KCur, 0, 8'(m_cur), cyc + 1);
    push(KFull, 0, {7'd0, m_cur == Visible}, cyc + 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called in the first busy cycle; expects exactly Depth busy cycles then a blank array.
  task automatic sweep_check();
    for (int k = 0; k < Depth; k++) begin
      push(KBusy, 0, 8'd1, cyc);
      push(KRdy, 0, 8'd0, cyc);
      tick();
    end
    in_valid = 1'b0;
    model_blank();
    push(KBusy, 0, 8'd0, cyc);
    push(KRdy, 0, 8'd1, cyc);
    push(KCur, 0, 8'd0, cyc);
    push(KFull, 0, 8'd0, cyc);
    push_all_ram(cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    clear_req = 1'b0;
    model_blank();
    tick();
    push(KRdy, 0, 8'd0, cyc);
    tick();
    rst = 1'b0;
    // Reset state.
    push(KRdy, 0, 8'd1, cyc);
    push(KCur, 0, 8'd0, cyc);
    push(KBusy, 0, 8'd0, cyc);
    push(KFull, 0, 8'd0, cyc);
    push(KOvf, 0, 8'd0, cyc);
    push_all_ram(cyc);

    // 'H','I' back to back.
    send(8'h48);
    send(8'h49);
    push(KRam, 0, 8'h48, cyc);
    push(KRam, 1, 8'h49, cyc);
    push(KCur, 0, 8'd2, cyc);
    push_all_ram(cyc);

    // Backspace twice, then once more at cursor 0; also an ignored control byte.
    send(8'h08);
    send(8'h08);
    send(8'h08);
    send(8'h07);
    push(KCur, 0, 8'd0, cyc);
    push(KRam, 0, 8'h20, cyc);
    push(KRam, 1, 8'h20, cyc);

    // 41 'A': last one dropped with a single-cycle overflow pulse.
    for (int i = 0; i < Visible + 1; i++) send(8'h41);
    push(KOvf, 0, 8'd0, cyc + 1);
    tick();
    push(KFull, 0, 8'd1, cyc);
    push(KCur, 0, 8'd40, cyc);
    push(KRam, 39, 8'h41, cyc);
    push(KRam, 40, 8'h20, cyc);
    push_all_ram(cyc);

    // Form feed clears the whole array.
    send(8'h0C);
    sweep_check();

    // Five chars, then clear_req with a concurrent byte that must not be taken.
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_char   = 8'h5A;
    push(KRdy, 0, 8'd0, cyc);
    tick();
    clear_req = 1'b0;
    push(KCur, 0, 8'd5, cyc);
    push(KRam, 4, 8'h65, cyc);
    push(KRam, 5, 8'h20, cyc);
    sweep_check();

    // Reset in the middle of a sweep.
    send(8'h58);
    send(8'h0C);
    for (int k = 0; k < 30; k++) begin
      push(KBusy, 0, 8'd1, cyc);
      tick();
    end
    rst = 1'b1;
    push(KRdy, 0, 8'd0, cyc);
    tick();
    rst = 1'b0;
    model_blank();
    push(KBusy, 0, 8'd0, cyc);
    push(KRdy, 0, 8'd1, cyc);
    push(KCur, 0, 8'd0, cyc);
    push(KOvf, 0, 8'd0, cyc);
    push_all_ram(cyc);
    send(8'h51);
    push(KRam, 0, 8'h51, cyc);
    push(KCur, 0, 8'd1, cyc);

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
